alu_arbiter: RTL

//  Shares the single registered 16-bit ALU between two requesters (A, B) via valid/ready handshakes.

---
 rtl/alu_arbiter.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sharing one registered 16-bit ALU between requesters A and B
// Optional grant statistics: define ALU_ARB_STATS_EN to add GrantCntA/GrantCntB saturating counters.
module alu_arbiter #(
  parameter int WIDTH = 16,
  parameter int OPW   = 3
`ifdef ALU_ARB_STATS_EN
  ,
  parameter int CNTW  = 16
`endif
) (
  input  logic             CLK,
  input  logic             RESETn,
  input  logic             ReqValidA,
  input  logic [OPW-1:0]   ReqOpA,
  input  logic [WIDTH-1:0] ReqAA,
  input  logic [WIDTH-1:0] ReqBA,
  output logic             ReqReadyA,
  input  logic             ReqValidB,
  input  logic [OPW-1:0]   ReqOpB,
  input  logic [WIDTH-1:0] ReqAB,
  input  logic [WIDTH-1:0] ReqBB,
  output logic             ReqReadyB,
  output logic [WIDTH-1:0] AluFirst,
  output logic [WIDTH-1:0] AluSecond,
  output logic [OPW-1:0]   AluOp,
  input  logic [WIDTH-1:0] AluResult,
  output logic             RespValid,
  output logic             RespId,
  output logic [WIDTH-1:0] RespData,
  input  logic             RespReady
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [CNTW-1:0]  GrantCntA,
  output logic [CNTW-1:0]  GrantCntB
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    CAPT = 2'd2,
    RESP = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] first_q, first_d;
  logic [WIDTH-1:0] second_q, second_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [OPW-1:0]   op_q, op_d;
  logic             id_q, id_d;
  logic             last_q, last_d;
  logic             grant_a, grant_b;

  // Pick at most one winner while idle and walk the fixed four-step sequence per op
  always_comb begin
    state_d = state_q;
    grant_a = 1'b0;
    grant_b = 1'b0;
    case (state_q)
      IDLE: begin
        if (ReqValidA && ReqValidB) begin
          // last_q = 1 means B was served last, so A wins the tie
          grant_a = last_q;
          grant_b = ~last_q;
        end else begin
          grant_a = ReqValidA;
          grant_b = ReqValidB;
        end
        if (grant_a || grant_b) begin
          state_d = EXEC;
        end
      end
      EXEC:    state_d = CAPT;
      CAPT:    state_d = RESP;
      RESP:    if (RespReady) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Latch the winner's op on the accept edge; capture the ALU result one cycle after EXEC
  always_comb begin
    first_d  = first_q;
    second_d = second_q;
    op_d     = op_q;
    id_d     = id_q;
    last_d   = last_q;
    data_d   = data_q;
    if (grant_a) begin
      first_d  = ReqAA;
      second_d = ReqBA;
      op_d     = ReqOpA;
      id_d     = 1'b0;
      last_d   = 1'b0;
    end else if (grant_b) begin
      first_d  = ReqAB;
      second_d = ReqBB;
      op_d     = ReqOpB;
      id_d     = 1'b1;
      last_d   = 1'b1;
    end
    if (state_q == CAPT) begin
      data_d = AluResult;
    end
  end

  // State and datapath registers; reset drops any op in flight
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q  <= IDLE;
      first_q  <= '0;
      second_q <= '0;
      op_q     <= '0;
      id_q     <= 1'b0;
      last_q   <= 1'b1;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      first_q  <= first_d;
      second_q <= second_d;
      op_q     <= op_d;
      id_q     <= id_d;
      last_q   <= last_d;
      data_q   <= data_d;
    end
  end

  // Ready is forced low while reset is held so a waiting requester never sees a stray accept
  assign ReqReadyA = grant_a & RESETn;
  assign ReqReadyB = grant_b & RESETn;

  // The ALU sees "clear" outside EXEC; operands stay put to avoid needless toggling
  assign AluFirst  = first_q;
  assign AluSecond = second_q;
  assign AluOp     = (state_q == EXEC) ? op_q : '0;

  assign RespValid = (state_q == RESP);
  assign RespId    = id_q;
  assign RespData  = data_q;

`ifdef ALU_ARB_STATS_EN
  logic [CNTW-1:0] cnt_a_q, cnt_a_d;
  logic [CNTW-1:0] cnt_b_q, cnt_b_d;

  // Saturating per-requester grant counters
  always_comb begin
    cnt_a_d = cnt_a_q;
    cnt_b_d = cnt_b_q;
    if (grant_a && (cnt_a_q != {CNTW{1'b1}})) begin
      cnt_a_d = cnt_a_q + CNTW'(1);
    end
    if (grant_b && (cnt_b_q != {CNTW{1'b1}})) begin
      cnt_b_d = cnt_b_q + CNTW'(1);
    end
  end

  // Counter registers
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      cnt_a_q <= '0;
      cnt_b_q <= '0;
    end else begin
      cnt_a_q <= cnt_a_d;
      cnt_b_q <= cnt_b_d;
    end
  end

  assign GrantCntA = cnt_a_q;
  assign GrantCntB = cnt_b_q;
`endif

endmodule
